ahb2apb_bridge: RTL and testbench

- Synthesisable AHB-Lite slave to APB master bridge; full RTL successor to the tie-off bridge model.
- Generalised to NSLV APB slaves with address decode, per-slave select/ready/error, write strobes and two-cycle AHB error response.
- Sits between the AHB interconnect slave port and the APB peripheral cluster.

---
 rtl/ahb2apb_bridge_pkg.sv | 34 +++
 rtl/ahb2apb_decode.sv | 31 +++
 rtl/ahb2apb_bridge.sv | 198 +++++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_bridge_pkg.sv
// ahb2apb_bridge_pkg: shared FSM state, AHB encodings and write-strobe helper.
// Used by ahb2apb_bridge and ahb2apb_decode.
package ahb2apb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // Byte-lane mask for a naturally aligned access of 2**size bytes.
   function automatic logic [15:0] f_pstrb(
      input logic [2:0]  size,
      input logic [3:0]  addr,
      input int unsigned nbytes
   );
      int unsigned n;
      int unsigned off;
      n   = 32'd1 << size;
      off = 32'(addr) & (nbytes - 32'd1) & ~(n - 32'd1);
      return 16'((32'd1 << n) - 32'd1) << off;
   endfunction

endpackage

// File: rtl/ahb2apb_decode.sv
// ahb2apb_decode: slave-select field to slot index, one-hot select
// and decode-error flag (slot out of range or oversize transfer).
module ahb2apb_decode
   import ahb2apb_bridge_pkg::*;
#(
   parameter int NSLV  = 5,
   parameter int SW    = 3,
   parameter int MAXSZ = 2
)(
   input  logic [SW-1:0]   i_field,
   input  logic [2:0]      i_hsize,
   output logic [SW-1:0]   o_slot,
   output logic [NSLV-1:0] o_psel,
   output logic            o_err
);

   logic w_range_err;
   logic w_size_err;

   assign o_slot      = i_field;
   assign w_range_err = 32'(i_field) >= NSLV;
   assign w_size_err  = 32'(i_hsize) > MAXSZ;
   assign o_err       = w_range_err | w_size_err;

   always_comb begin
      o_psel = '0;
      for (int i = 0; i < NSLV; i++)
         o_psel[i] = !o_err && (32'(i_field) == i);
   end

endmodule

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to NSLV-port APB master bridge.
// Define AHB2APB_TIMEOUT_EN to abort APB accesses after TIMEOUT cycles.
module ahb2apb_bridge
   import ahb2apb_bridge_pkg::*;
#(
   parameter int HADDR   = 32,
   parameter int HDATA   = 32,
   parameter int PDATA   = 32,
   parameter int NSLV    = 5,
   parameter int SLV_LSB = 12,
   parameter int TIMEOUT = 256
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  hsel,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hburst,
   input  logic [2:0]            hsize,
   input  logic [3:0]            hprot,
   input  logic                  hmastlock,
   input  logic [HADDR-1:0]      haddr,
   input  logic                  hwrite,
   input  logic [HDATA-1:0]      hwdata,
   output logic [HDATA-1:0]      hrdata,
   output logic                  hresp,
   output logic                  hreadyout,
   input  logic                  hready,
   output logic [NSLV-1:0]       psel,
   output logic                  penable,
   output logic [2:0]            pprot,
   output logic [SLV_LSB-1:0]    paddr,
   output logic                  pwrite,
   output logic [PDATA/8-1:0]    pstrb,
   output logic [PDATA-1:0]      pwdata,
   input  logic [NSLV*PDATA-1:0] prdata,
   input  logic [NSLV-1:0]       pslverr,
   input  logic [NSLV-1:0]       pready
);

   localparam int SW    = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int NB    = PDATA / 8;
   localparam int MAXSZ = $clog2(NB);

   if (PDATA != HDATA || TIMEOUT < 1) begin : g_bad_cfg
      $error("ahb2apb_bridge: PDATA must equal HDATA and TIMEOUT >= 1");
   end

   state_t            r_state;
   logic [SW-1:0]     r_slot;
   logic [NSLV-1:0]   r_psel;
   logic              r_penable;
   logic [2:0]        r_pprot;
   logic [SLV_LSB-1:0] r_paddr;
   logic              r_pwrite;
   logic [NB-1:0]     r_pstrb;
   logic [PDATA-1:0]  r_pwdata;
   logic [HDATA-1:0]  r_hrdata;
   logic              r_hresp;
   logic              r_hreadyout;
`ifdef AHB2APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]     r_cnt;
`endif

   logic [SW-1:0]     w_slot;
   logic [NSLV-1:0]   w_psel;
   logic              w_derr;
   logic              w_cap;
   logic              w_pready;
   logic              w_slverr;
   logic [PDATA-1:0]  w_prdata;
   logic              w_unused;

   ahb2apb_decode #(
      .NSLV  (NSLV),
      .SW    (SW),
      .MAXSZ (MAXSZ)
   ) u_decode (
      .i_field (haddr[SLV_LSB +: SW]),
      .i_hsize (hsize),
      .o_slot  (w_slot),
      .o_psel  (w_psel),
      .o_err   (w_derr)
   );

   assign w_cap = hsel & hready &
                  !(htrans inside {HTRANS_IDLE, HTRANS_BUSY});

   always_comb begin
      w_prdata = '0;
      w_pready = 1'b0;
      w_slverr = 1'b0;
      for (int i = 0; i < NSLV; i++)
         if (r_slot == SW'(i)) begin
            w_prdata = prdata[i*PDATA +: PDATA];
            w_pready = pready[i];
            w_slverr = pslverr[i];
         end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_pprot     <= '0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pstrb     <= '0;
         r_pwdata    <= '0;
         r_hrdata    <= '0;
         r_hresp     <= HRESP_OKAY;
         r_hreadyout <= 1'b1;
`ifdef AHB2APB_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
               r_hresp     <= HRESP_OKAY;
               r_hreadyout <= 1'b1;
               r_state     <= ST_IDLE;
               if (w_cap) begin
                  r_hreadyout <= 1'b0;
                  if (w_derr) begin
                     r_hresp <= HRESP_ERROR;
                     r_state <= ST_ERR1;
                  end else begin
                     r_state  <= ST_SETUP;
                     r_slot   <= w_slot;
                     r_psel   <= w_psel;
                     r_paddr  <= haddr[SLV_LSB-1:0];
                     r_pwrite <= hwrite;
                     r_pstrb  <= hwrite ? NB'(f_pstrb(hsize, haddr[3:0], NB)) : '0;
                     r_pprot  <= {~hprot[0], 1'b0, hprot[1]};
                  end
               end
            end
            ST_SETUP: begin
               r_pwdata  <= hwdata;
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
`ifdef AHB2APB_TIMEOUT_EN
               r_cnt     <= '0;
`endif
            end
            ST_ACCESS: begin
               if (w_pready) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  if (!r_pwrite)
                     r_hrdata <= w_prdata;
                  if (w_slverr) begin
                     r_hresp <= HRESP_ERROR;
                     r_state <= ST_ERR1;
                  end else begin
                     r_hreadyout <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
`ifdef AHB2APB_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_hresp   <= HRESP_ERROR;
                  r_state   <= ST_ERR1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
`endif
            end
            ST_ERR1: begin
               r_hresp     <= HRESP_ERROR;
               r_hreadyout <= 1'b1;
               r_state     <= ST_ERR2;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write data is taken live from the AHB data phase during SETUP.
   assign pwdata    = (r_state == ST_SETUP) ? hwdata : r_pwdata;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pprot     = r_pprot;
   assign paddr     = r_paddr;
   assign pwrite    = r_pwrite;
   assign pstrb     = r_pstrb;
   assign hrdata    = r_hrdata;
   assign hresp     = r_hresp;
   assign hreadyout = r_hreadyout;

   assign w_unused = &{1'b0, hburst, hmastlock, hprot[3:2],
                       haddr[HADDR-1:SLV_LSB+SW]};

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: table, hand-written and random transfers against
// a transaction-level model of the AHB-to-APB bridge.
module tb_ahb2apb_bridge;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [3:0]  prot;
      logic [31:0] wdata;
      int          waits;
      logic        slverr;
      logic [31:0] rdata;
   } req_t;

   typedef struct {
      logic [4:0]  psel;
      logic [11:0] paddr;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
      int          nwait;
      logic        resp;
      logic        derr;
   } exp_t;

   typedef struct {
      req_t r;
      exp_t e;
   } vec_t;

   typedef struct {
      int          nwait;
      int          nacc;
      logic        resp;
      logic        err1;
      logic [4:0]  psel;
      logic [11:0] paddr;
      logic        pwrite;
      logic [3:0]  pstrb;
      logic [31:0] pwdata;
      logic [2:0]  pprot;
      logic [31:0] hrdata;
      logic        stable;
   } obs_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         hsel, hwrite, hready, hmastlock;
   logic [1:0]   htrans;
   logic [2:0]   hburst, hsize;
   logic [3:0]   hprot;
   logic [31:0]  haddr, hwdata, hrdata;
   logic         hresp, hreadyout;
   logic [4:0]   psel, pslverr, pready;
   logic         penable, pwrite;
   logic [2:0]   pprot;
   logic [11:0]  paddr;
   logic [3:0]   pstrb;
   logic [31:0]  pwdata;
   logic [159:0] prdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ahb2apb_bridge #(.TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n), .hsel(hsel), .htrans(htrans),
      .hburst(hburst), .hsize(hsize), .hprot(hprot),
      .hmastlock(hmastlock), .haddr(haddr), .hwrite(hwrite),
      .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp),
      .hreadyout(hreadyout), .hready(hready), .psel(psel),
      .penable(penable), .pprot(pprot), .paddr(paddr),
      .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
      .prdata(prdata), .pslverr(pslverr), .pready(pready)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: what one AHB transfer should look like on both buses.
   function automatic exp_t model(input req_t r);
      exp_t e;
      int slot, nb, lane;
      slot   = int'(r.addr[14:12]);
      nb     = 1 << r.size;
      e.derr = (slot >= 5) || (r.size > 2);
      e.psel = e.derr ? 5'd0 : 5'(1 << slot);
      e.paddr = 12'(r.addr % 4096);
      lane   = (int'(r.addr % 4) / nb) * nb;
      e.pstrb = (r.wr && !e.derr) ? 4'(((1 << nb) - 1) << lane) : 4'd0;
      e.pprot = {~r.prot[0], 1'b0, r.prot[1]};
      e.resp  = e.derr || r.slverr;
      e.nwait = e.derr ? 1 : (r.slverr ? r.waits + 3 : r.waits + 2);
      return e;
   endfunction

   function automatic vec_t mkv(
      input logic [31:0] a, input logic w, input logic [2:0] s,
      input logic [3:0] p, input logic [31:0] wd, input int wt,
      input logic se, input logic [31:0] rd, input logic [4:0] ps,
      input logic [11:0] pa, input logic [3:0] st, input logic [2:0] pp,
      input int nw, input logic rs, input logic de);
      vec_t v;
      v.r = '{addr: a, wr: w, size: s, prot: p, wdata: wd, waits: wt,
              slverr: se, rdata: rd};
      v.e = '{psel: ps, paddr: pa, pstrb: st, pprot: pp, nwait: nw,
              resp: rs, derr: de};
      return v;
   endfunction

   // Drives one transfer starting at a negedge; returns at the negedge
   // where hreadyout=1 ends its data phase.
   task automatic xfer(input req_t r, output obs_t o);
      int slot, acc, cyc;
      bit seen, done;
      slot = int'(r.addr[14:12]);
      o = '{default: 0};
      o.stable = 1'b1;
      seen = 0; done = 0; acc = 0; cyc = 0;
      hsel = 1; hready = 1; htrans = 2'b10; haddr = r.addr;
      hwrite = r.wr; hsize = r.size; hprot = r.prot; hwdata = r.wdata;
      hburst = 3'($urandom);
      @(negedge clk);
      while (!done && cyc < 300) begin
         if (psel != 0 && !penable && !seen) begin
            seen = 1;
            o.psel = psel; o.paddr = paddr; o.pwrite = pwrite;
            o.pstrb = pstrb; o.pwdata = pwdata; o.pprot = pprot;
         end
         if (psel != 0 && penable)
            if (psel !== o.psel || paddr !== o.paddr ||
                pwrite !== o.pwrite || pstrb !== o.pstrb ||
                pwdata !== o.pwdata || pprot !== o.pprot)
               o.stable = 1'b0;
         if (hreadyout) begin
            done = 1; o.resp = hresp; o.hrdata = hrdata;
         end else begin
            o.nwait++;
            if (hresp) o.err1 = 1'b1;
         end
         htrans = {1'b0, 1'($urandom)};
         hsel = 1'($urandom); haddr = $urandom;
         hwrite = 1'($urandom); hsize = 3'($urandom);
         pready = 5'($urandom); pslverr = 5'($urandom);
         for (int i = 0; i < 5; i++) prdata[i*32 +: 32] = $urandom;
         if (slot < 5) begin
            pready[slot] = 1'b0; pslverr[slot] = 1'b0;
         end
         if (psel != 0 && penable) begin
            if (acc == r.waits && slot < 5) begin
               pready[slot] = 1'b1;
               pslverr[slot] = r.slverr;
               prdata[slot*32 +: 32] = r.rdata;
            end
            acc++;
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      o.nacc = acc;
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL xfer_bound: no hreadyout for addr %h", r.addr);
      end
   endtask

   task automatic check(input string t, input req_t r, input exp_t e,
                        input obs_t o);
      chk({t, " nwait"}, 64'(o.nwait), 64'(e.nwait));
      chk({t, " hresp"}, o.resp, e.resp);
      chk({t, " err1"}, o.err1, e.resp);
      chk({t, " psel"}, o.psel, e.psel);
      if (!e.derr) begin
         chk({t, " paddr"}, o.paddr, e.paddr);
         chk({t, " pwrite"}, o.pwrite, r.wr);
         chk({t, " pstrb"}, o.pstrb, e.pstrb);
         chk({t, " pprot"}, o.pprot, e.pprot);
         chk({t, " stable"}, o.stable, 1'b1);
         if (r.wr) chk({t, " pwdata"}, o.pwdata, r.wdata);
         if (!r.wr && !r.slverr) chk({t, " hrdata"}, o.hrdata, r.rdata);
      end
   endtask

   task automatic chk_reset(input string t);
      chk({t, " hrdata"}, hrdata, 32'd0);
      chk({t, " hresp"}, hresp, 1'b0);
      chk({t, " hreadyout"}, hreadyout, 1'b1);
      chk({t, " psel"}, psel, 5'd0);
      chk({t, " penable"}, penable, 1'b0);
      chk({t, " pprot"}, pprot, 3'd0);
      chk({t, " paddr"}, paddr, 12'd0);
      chk({t, " pwrite"}, pwrite, 1'b0);
      chk({t, " pstrb"}, pstrb, 4'd0);
      chk({t, " pwdata"}, pwdata, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      req_t r;
      exp_t e;
      obs_t o;

      tbl[0] = mkv(32'h0000_2004, 1, 2, 4'h3, 32'hDEAD_BEEF, 0, 0, 0,
                   5'b00100, 12'h004, 4'hF, 3'b001, 2, 0, 0);
      tbl[1] = mkv(32'h0000_1008, 0, 2, 4'h0, 32'h0, 3, 0, 32'h1234_5678,
                   5'b00010, 12'h008, 4'h0, 3'b100, 5, 0, 0);
      tbl[2] = mkv(32'h0000_0003, 1, 0, 4'h2, 32'hA5A5_A5A5, 0, 0, 0,
                   5'b00001, 12'h003, 4'b1000, 3'b101, 2, 0, 0);
      tbl[3] = mkv(32'h0000_7000, 0, 2, 4'h0, 32'h0, 0, 0, 0,
                   5'b00000, 12'h000, 4'h0, 3'b100, 1, 1, 1);
      tbl[4] = mkv(32'h0000_0010, 1, 2, 4'h0, 32'h1111_2222, 1, 1, 0,
                   5'b00001, 12'h010, 4'hF, 3'b100, 4, 1, 0);
      tbl[5] = mkv(32'h0000_4ABE, 1, 1, 4'h3, 32'hCAFE_F00D, 2, 0, 0,
                   5'b10000, 12'hABE, 4'b1100, 3'b001, 4, 0, 0);
      tbl[6] = mkv(32'h0000_3000, 0, 3, 4'h0, 32'h0, 0, 0, 0,
                   5'b00000, 12'h000, 4'h0, 3'b100, 1, 1, 1);
      tbl[7] = mkv(32'h0000_3FFD, 0, 0, 4'h0, 32'h0, 0, 0, 32'h8765_4321,
                   5'b01000, 12'hFFD, 4'h0, 3'b100, 2, 0, 0);

      reset_n = 0; hsel = 0; htrans = 0; hburst = 0; hsize = 0;
      hprot = 0; hmastlock = 0; haddr = 0; hwrite = 0; hwdata = 0;
      hready = 1; prdata = '0; pslverr = 0; pready = 0;
      repeat (3) @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      chk_reset("reset");

      // No capture when hready is low, on BUSY, or when not selected.
      hsel = 1; hready = 0; htrans = 2'b10; haddr = 32'h2000;
      @(negedge clk);
      chk("hready_low psel", psel, 5'd0);
      chk("hready_low hreadyout", hreadyout, 1'b1);
      hready = 1; htrans = 2'b01;
      @(negedge clk);
      chk("busy psel", psel, 5'd0);
      hsel = 0; htrans = 2'b10;
      @(negedge clk);
      chk("unsel psel", psel, 5'd0);
      htrans = 2'b00;
      @(negedge clk);

      // Row 5 follows an slverr row, so it is captured during ERR2.
      for (int i = 0; i < 8; i++) begin
         xfer(tbl[i].r, o);
         check($sformatf("tbl%0d", i), tbl[i].r, tbl[i].e, o);
      end

      for (int k = 0; k < 40; k++) begin
         r.size   = 3'($urandom_range(0, 3));
         r.addr   = $urandom & ~((32'd1 << r.size) - 32'd1);
         r.wr     = 1'($urandom);
         r.prot   = 4'($urandom);
         r.wdata  = $urandom;
         r.waits  = $urandom_range(0, 4);
         r.slverr = ($urandom_range(0, 7) == 0);
         r.rdata  = $urandom;
         e = model(r);
         xfer(r, o);
         check($sformatf("rnd%0d", k), r, e, o);
      end

`ifdef AHB2APB_TIMEOUT_EN
      r = '{addr: 32'h2010, wr: 1, size: 2, prot: 0, wdata: 32'h55,
            waits: 1000, slverr: 0, rdata: 0};
      xfer(r, o);
      chk("tmo nacc", 64'(o.nacc), 64'd16);
      chk("tmo nwait", 64'(o.nwait), 64'd18);
      chk("tmo hresp", o.resp, 1'b1);
      chk("tmo err1", o.err1, 1'b1);
      chk("tmo psel", o.psel, 5'b00100);
`endif

      // Asynchronous reset in the middle of an ACCESS phase.
      hsel = 1; hready = 1; htrans = 2'b10; haddr = 32'h1000;
      hwrite = 0; hsize = 2; hprot = 4'h3; hwdata = 32'hFFFF_0000;
      pready = 0;
      @(negedge clk);
      hsel = 0; htrans = 2'b00;
      @(negedge clk);
      chk("midrst penable", penable, 1'b1);
      chk("midrst psel", psel, 5'b00010);
      #2 reset_n = 0;
      #1 chk_reset("midrst");
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      chk("postrst psel", psel, 5'd0);
      chk("postrst hreadyout", hreadyout, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
